// File: rtl/sat_frame_accumulator_if.sv
`default_nettype none
// ============================================================================
// sat_frame_accumulator_if : sample-in / frame-sum-out handshake bundle
// Revision 1.0 - initial release
// ============================================================================
interface sat_frame_accumulator_if #(
  parameter int BITWIDTH = 32
);
  logic                clear;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_data;
  logic                out_sat;

  // Producer of samples / consumer of frame results.
  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The accumulator itself.
  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/sat_frame_accumulator.sv
`default_nettype none
// ============================================================================
// sat_frame_accumulator : per-frame signed sum with clamp-at-every-add
// Revision 1.0 - initial release
// ============================================================================
module sat_frame_accumulator #(
  parameter int BITWIDTH  = 32,
  parameter int FRAME_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sat_frame_accumulator_if.slave   bus
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]           LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [BITWIDTH-1:0] MAX_POS  = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [BITWIDTH-1:0] MIN_NEG  = {1'b1, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e                      slot_q, slot_d;
  logic signed [BITWIDTH-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic                       sat_sticky_q, sat_sticky_d;
  logic signed [BITWIDTH-1:0] out_data_q, out_data_d;
  logic                       out_sat_q, out_sat_d;

  logic signed [BITWIDTH:0]   sum_w;
  logic signed [BITWIDTH-1:0] add_res;
  logic                       add_clamp;
  logic                       in_ready;
  logic                       accept;
  logic                       frame_end;

  // One guard bit is enough: the two top bits disagree exactly on overflow.
  always_comb begin
    sum_w     = {acc_q[BITWIDTH-1], acc_q} + {bus.in_data[BITWIDTH-1], bus.in_data};
    add_res   = sum_w[BITWIDTH-1:0];
    add_clamp = sum_w[BITWIDTH] ^ sum_w[BITWIDTH-1];
    case (sum_w[BITWIDTH:BITWIDTH-1])
      2'b01:   add_res = MAX_POS;
      2'b10:   add_res = MIN_NEG;
      default: add_res = sum_w[BITWIDTH-1:0];
    endcase
  end

  always_comb begin
    in_ready  = !bus.clear && ((slot_q == SLOT_EMPTY) || bus.out_ready);
    accept    = bus.in_valid && in_ready;
    frame_end = accept && (cnt_q == LAST_IDX);
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sat_sticky_d = sat_sticky_q;
    out_data_d   = out_data_q;
    out_sat_d    = out_sat_q;

    if (bus.clear) begin
      acc_d        = '0;
      cnt_d        = '0;
      sat_sticky_d = 1'b0;
    end else if (frame_end) begin
      out_data_d   = add_res;
      out_sat_d    = sat_sticky_q | add_clamp;
      acc_d        = '0;
      cnt_d        = '0;
      sat_sticky_d = 1'b0;
    end else if (accept) begin
      acc_d        = add_res;
      cnt_d        = cnt_q + CNT_W'(1);
      sat_sticky_d = sat_sticky_q | add_clamp;
    end
  end

  // A frame end landing on a drain cycle reloads the slot, so it stays full.
  always_comb begin
    slot_d = slot_q;
    case (slot_q)
      SLOT_EMPTY: if (frame_end) slot_d = SLOT_FULL;
      SLOT_FULL: begin
        if (frame_end)          slot_d = SLOT_FULL;
        else if (bus.out_ready) slot_d = SLOT_EMPTY;
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= SLOT_EMPTY;
      acc_q        <= '0;
      cnt_q        <= '0;
      sat_sticky_q <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sat_sticky_q <= sat_sticky_d;
      out_data_q   <= out_data_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (slot_q == SLOT_FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_sat_frame_accumulator.sv
`default_nettype none
// ============================================================================
// tb_sat_frame_accumulator : vector table, corner sequences, random vs model
// Revision 1.0 - initial release
// ============================================================================
module tb_sat_frame_accumulator;

  localparam int BW = 8;
  localparam int FL = 4;
  localparam int MAXV = 127;
  localparam int MINV = -128;

  logic clk;
  logic rst_n;

  sat_frame_accumulator_if #(.BITWIDTH(BW)) bus ();

  sat_frame_accumulator #(
    .BITWIDTH (BW),
    .FRAME_LEN(FL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: keeps the frame's samples and folds them at frame end.
  int q_samp[$];
  bit m_ov;
  int m_od;
  bit m_os;

  function automatic bit m_ready(input bit clr, input bit ordy);
    return !clr && (!m_ov || ordy);
  endfunction

  task automatic model_reset();
    q_samp.delete();
    m_ov = 0;
    m_od = 0;
    m_os = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit clr, input bit ordy);
    bit fe;
    int total;
    bit any;
    fe = 0;
    if (clr) q_samp.delete();
    else if (v && m_ready(clr, ordy)) begin
      q_samp.push_back(d);
      if (q_samp.size() == FL) begin
        total = 0;
        any   = 0;
        foreach (q_samp[i]) begin
          total = total + q_samp[i];
          if (total > MAXV) begin total = MAXV; any = 1; end
          if (total < MINV) begin total = MINV; any = 1; end
        end
        m_od = total;
        m_os = any;
        fe   = 1;
        q_samp.delete();
      end
    end
    if (fe) m_ov = 1;
    else if (m_ov && ordy) m_ov = 0;
  endtask

  int act_rdy;

  // Inputs change just after an edge; in_ready sampled mid-cycle; outputs 1 after the edge.
  task automatic drive_cycle(input bit v, input int d, input bit clr, input bit ordy);
    bus.in_valid  = v;
    bus.in_data   = BW'(d);
    bus.clear     = clr;
    bus.out_ready = ordy;
    #1;
    act_rdy = int'(bus.in_ready);
    @(posedge clk);
    model_edge(v, d, clr, ordy);
    #1;
  endtask

  function automatic int od_s();
    return int'($signed(bus.out_data));
  endfunction

  typedef struct {
    bit v;
    int d;
    bit clr;
    bit ordy;
    bit e_rdy;
    bit e_ov;
    int e_od;
    bit e_os;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // basic sum
    tbl.push_back('{1,   10, 0, 1, 1, 0,    0, 0});
    tbl.push_back('{1,   20, 0, 1, 1, 0,    0, 0});
    tbl.push_back('{1,   30, 0, 1, 1, 0,    0, 0});
    tbl.push_back('{1,   40, 0, 1, 1, 1,  100, 0});
    tbl.push_back('{0,    0, 0, 1, 1, 0,  100, 0});
    // positive clamp mid-frame
    tbl.push_back('{1,  100, 0, 1, 1, 0,  100, 0});
    tbl.push_back('{1,  100, 0, 1, 1, 0,  100, 0});
    tbl.push_back('{1,  -50, 0, 1, 1, 0,  100, 0});
    tbl.push_back('{1,  -50, 0, 1, 1, 1,   27, 1});
    // negative clamp
    tbl.push_back('{1, -100, 0, 1, 1, 0,   27, 1});
    tbl.push_back('{1, -100, 0, 1, 1, 0,   27, 1});
    tbl.push_back('{1, -100, 0, 1, 1, 0,   27, 1});
    tbl.push_back('{1,    5, 0, 1, 1, 1, -123, 1});
    // clear discards the partial frame
    tbl.push_back('{1,    1, 0, 1, 1, 0, -123, 1});
    tbl.push_back('{1,    2, 0, 1, 1, 0, -123, 1});
    tbl.push_back('{1,   99, 1, 1, 0, 0, -123, 1});
    tbl.push_back('{1,    3, 0, 1, 1, 0, -123, 1});
    tbl.push_back('{1,    4, 0, 1, 1, 0, -123, 1});
    tbl.push_back('{1,    5, 0, 1, 1, 0, -123, 1});
    tbl.push_back('{1,    6, 0, 1, 1, 1,   18, 0});
    tbl.push_back('{0,    0, 0, 1, 1, 0,   18, 0});

    bus.in_valid  = 1'b1;
    bus.in_data   = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", int'(bus.out_valid), 0);
    check("reset out_data",  od_s(), 0);
    check("reset out_sat",   int'(bus.out_sat), 0);
    check("reset in_ready",  int'(bus.in_ready), 1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].ordy);
      check($sformatf("tbl[%0d] in_ready", i),  act_rdy, int'(tbl[i].e_rdy));
      check($sformatf("tbl[%0d] out_valid", i), int'(bus.out_valid), int'(tbl[i].e_ov));
      check($sformatf("tbl[%0d] out_data", i),  od_s(), tbl[i].e_od);
      check($sformatf("tbl[%0d] out_sat", i),   int'(bus.out_sat), int'(tbl[i].e_os));
    end

    // backpressure: result held, input stalled, no sample lost on release
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 0);
    check("bp first result valid", int'(bus.out_valid), 1);
    check("bp first result data", od_s(), 4);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 2, 0, 0);
      check("bp stall in_ready", act_rdy, 0);
      check("bp stall out_valid", int'(bus.out_valid), 1);
      check("bp stall out_data", od_s(), 4);
    end
    drive_cycle(1, 2, 0, 1);
    check("bp release in_ready", act_rdy, 1);
    check("bp release drains", int'(bus.out_valid), 0);
    for (int i = 0; i < 3; i++) drive_cycle(1, 2, 0, 1);
    check("bp second result valid", int'(bus.out_valid), 1);
    check("bp second result data", od_s(), 8);

    // asynchronous reset mid-frame
    drive_cycle(1, 50, 0, 1);
    drive_cycle(1, 50, 0, 1);
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", int'(bus.out_valid), 0);
    check("async rst out_data",  od_s(), 0);
    check("async rst out_sat",   int'(bus.out_sat), 0);
    check("async rst in_ready",  int'(bus.in_ready), 1);
    model_reset();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 0, 1);
    check("post rst valid", int'(bus.out_valid), 1);
    check("post rst data", od_s(), 4);

    // back-to-back frames at full rate: no stall, one result per frame
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        drive_cycle(1, f + 3, 0, 1);
        check("b2b in_ready", act_rdy, 1);
        check("b2b out_valid", int'(bus.out_valid), (i == 3) ? 1 : 0);
      end
      check("b2b data", od_s(), 4 * (f + 3));
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit  v;
      bit  clr;
      bit  ordy;
      logic [7:0] r;
      bit  exp_rdy;
      v    = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      r    = 8'($urandom);
      if ($urandom_range(0, 1) == 0) r = 8'($signed(7'($urandom)));
      exp_rdy = m_ready(clr, ordy);
      drive_cycle(v, int'($signed(r)), clr, ordy);
      check("rnd in_ready",  act_rdy, int'(exp_rdy));
      check("rnd out_valid", int'(bus.out_valid), int'(m_ov));
      check("rnd out_data",  od_s(), m_od);
      check("rnd out_sat",   int'(bus.out_sat), int'(m_os));
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rnd async rst out_valid", int'(bus.out_valid), 0);
        #1;
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
